// File: rtl/uart_cmd_master_pkg.sv
// Shared types and helpers for the UART command master: FSM states, command
// field positions and the frame parity function.
package uart_cmd_master_pkg;

  localparam int unsigned MAX_FRAME_BITS = 9;

  typedef enum logic [3:0] {
    IDLE,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP,
    GAP,
    RX_WAIT,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP,
    DONE
  } state_e;

  // Bit position of the read/write flag inside a command word
  function automatic int unsigned cmd_rw_idx(input int unsigned frame_bits);
    return 2 * frame_bits - 1;
  endfunction

  // Zero-extended payload bits do not change the XOR, so one width serves all frames
  function automatic logic parity_fn(input logic [MAX_FRAME_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_cmd_master_if.sv
// Host-side command/response bundle of the UART command master.
interface uart_cmd_master_if #(
  parameter int unsigned FRAME_BITS = 8
);

  localparam int unsigned CMD_W = 2 * FRAME_BITS;

  logic [CMD_W-1:0]      cmd_in;
  logic                  cmd_vld;
  logic                  cmd_rdy;
  logic [FRAME_BITS-1:0] read_data;
  logic                  read_vld;
  logic                  err_parity;
  logic                  err_frame;
  logic                  err_timeout;

  modport master (
    output cmd_in, cmd_vld,
    input  cmd_rdy, read_data, read_vld, err_parity, err_frame, err_timeout
  );

  modport slave (
    input  cmd_in, cmd_vld,
    output cmd_rdy, read_data, read_vld, err_parity, err_frame, err_timeout
  );

endinterface

// File: rtl/uart_cmd_master_baud_cnt.sv
// Bit-time counter shared by the TX and RX paths; restarts on clr.
module uart_cmd_master_baud_cnt #(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick_end,
  output logic tick_mid
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_end = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign tick_mid = (cnt_q == CNT_W'(CLK_DIV / 2));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || tick_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_master.sv
// UART register-access master: sends a two-frame write, or an address frame
// followed by capture of one reply frame, reporting parity/framing/timeout errors.
module uart_cmd_master
  import uart_cmd_master_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned FRAME_BITS = 8,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned GAP_BITS   = 16,
  parameter int unsigned RX_TO_BITS = 64
) (
  input  logic               clk,
  input  logic               rst,
  uart_cmd_master_if.slave   bus,
  input  logic               rx,
  output logic               tx
);

  localparam int unsigned CMD_W   = 2 * FRAME_BITS;
  localparam int unsigned CMD_RW  = cmd_rw_idx(FRAME_BITS);
  localparam int unsigned BIT_MX0 = (FRAME_BITS > GAP_BITS) ? FRAME_BITS : GAP_BITS;
  localparam int unsigned BIT_MAX = (BIT_MX0 > STOP_BITS) ? BIT_MX0 : STOP_BITS;
  localparam int unsigned BIT_W   = $clog2(BIT_MAX + 1);
  localparam int unsigned TO_W    = $clog2(RX_TO_BITS + 1);
  localparam logic        PAR_ODD = (PARITY_ODD != 0);
  localparam state_e      TX_AFTER_DATA = (PARITY_EN != 0) ? TX_PAR : TX_STOP;
  localparam state_e      RX_AFTER_DATA = (PARITY_EN != 0) ? RX_PAR : RX_STOP;

  state_e                state_q, state_d;
  logic [CMD_W-1:0]      cmd_q, cmd_d;
  logic                  frame_sel_q, frame_sel_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [FRAME_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                  rx_s1_q, rx_s1_d;
  logic                  rx_s2_q, rx_s2_d;
  logic                  rx_prev_q, rx_prev_d;
  logic                  tx_q, tx_d;
  logic                  cmd_rdy_q, cmd_rdy_d;
  logic                  read_vld_q, read_vld_d;
  logic [FRAME_BITS-1:0] read_data_q, read_data_d;
  logic                  err_parity_q, err_parity_d;
  logic                  err_frame_q, err_frame_d;
  logic                  err_timeout_q, err_timeout_d;

  logic                  tick_end_c;
  logic                  tick_mid_c;
  logic                  baud_clr_c;
  logic                  rx_fall_c;
  logic [FRAME_BITS-1:0] tx_frame_c;
  logic [FRAME_BITS-1:0] tx_shift_c;

  // Every state change restarts the bit timer, so bit edges follow the FSM
  assign baud_clr_c = (state_d != state_q);
  assign rx_fall_c  = rx_prev_q & ~rx_s2_q;

  uart_cmd_master_baud_cnt #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clr      (baud_clr_c),
    .tick_end (tick_end_c),
    .tick_mid (tick_mid_c)
  );

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    frame_sel_d   = frame_sel_q;
    bit_cnt_d     = bit_cnt_q;
    to_cnt_d      = to_cnt_q;
    rx_shift_d    = rx_shift_q;
    read_vld_d    = 1'b0;
    read_data_d   = read_data_q;
    err_parity_d  = err_parity_q;
    err_frame_d   = err_frame_q;
    err_timeout_d = err_timeout_q;
    rx_s1_d       = rx;
    rx_s2_d       = rx_s1_q;
    rx_prev_d     = rx_s2_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_vld && cmd_rdy_q) begin
          cmd_d         = bus.cmd_in;
          frame_sel_d   = 1'b0;
          err_parity_d  = 1'b0;
          err_frame_d   = 1'b0;
          err_timeout_d = 1'b0;
          state_d       = TX_START;
        end
      end
      TX_START: begin
        if (tick_end_c) begin
          bit_cnt_d = '0;
          state_d   = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tick_end_c) begin
          if (bit_cnt_q == BIT_W'(FRAME_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = TX_AFTER_DATA;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      TX_PAR: begin
        if (tick_end_c) begin
          bit_cnt_d = '0;
          state_d   = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tick_end_c) begin
          if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
            bit_cnt_d = '0;
            if (!cmd_q[CMD_RW]) begin
              to_cnt_d = '0;
              state_d  = RX_WAIT;
            end else if (!frame_sel_q) begin
              state_d = GAP;
            end else begin
              state_d = DONE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      GAP: begin
        if (tick_end_c) begin
          if (bit_cnt_q == BIT_W'(GAP_BITS - 1)) begin
            bit_cnt_d   = '0;
            frame_sel_d = 1'b1;
            state_d     = TX_START;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      // Timeout count survives glitch bounces through RX_START
      RX_WAIT: begin
        if (rx_fall_c) begin
          state_d = RX_START;
        end else if (tick_end_c) begin
          if (to_cnt_q == TO_W'(RX_TO_BITS - 1)) begin
            err_timeout_d = 1'b1;
            read_vld_d    = 1'b1;
            state_d       = DONE;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
      end
      // Restarting the timer at mid start bit puts later tick_end on mid-bit
      RX_START: begin
        if (tick_mid_c) begin
          bit_cnt_d = '0;
          state_d   = rx_s2_q ? RX_WAIT : RX_DATA;
        end
      end
      RX_DATA: begin
        if (tick_end_c) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[FRAME_BITS-1:1]};
          if (bit_cnt_q == BIT_W'(FRAME_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = RX_AFTER_DATA;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      RX_PAR: begin
        if (tick_end_c) begin
          err_parity_d = rx_s2_q ^ parity_fn(MAX_FRAME_BITS'(rx_shift_q), PAR_ODD);
          state_d      = RX_STOP;
        end
      end
      RX_STOP: begin
        if (tick_end_c) begin
          err_frame_d = ~rx_s2_q;
          read_data_d = rx_shift_q;
          read_vld_d  = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Ready rises one cycle after returning to IDLE and drops on acceptance
    cmd_rdy_d = (state_q == IDLE) && (state_d == IDLE);

    // tx is registered from the next state so the line tracks the FSM exactly
    tx_frame_c = frame_sel_d ? cmd_d[FRAME_BITS-1:0] : cmd_d[CMD_W-1:FRAME_BITS];
    tx_shift_c = tx_frame_c >> bit_cnt_d;
    case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_shift_c[0];
      TX_PAR:   tx_d = parity_fn(MAX_FRAME_BITS'(tx_frame_c), PAR_ODD);
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      frame_sel_q   <= 1'b0;
      bit_cnt_q     <= '0;
      to_cnt_q      <= '0;
      rx_shift_q    <= '0;
      rx_s1_q       <= 1'b1;
      rx_s2_q       <= 1'b1;
      rx_prev_q     <= 1'b1;
      tx_q          <= 1'b1;
      cmd_rdy_q     <= 1'b1;
      read_vld_q    <= 1'b0;
      read_data_q   <= '0;
      err_parity_q  <= 1'b0;
      err_frame_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      frame_sel_q   <= frame_sel_d;
      bit_cnt_q     <= bit_cnt_d;
      to_cnt_q      <= to_cnt_d;
      rx_shift_q    <= rx_shift_d;
      rx_s1_q       <= rx_s1_d;
      rx_s2_q       <= rx_s2_d;
      rx_prev_q     <= rx_prev_d;
      tx_q          <= tx_d;
      cmd_rdy_q     <= cmd_rdy_d;
      read_vld_q    <= read_vld_d;
      read_data_q   <= read_data_d;
      err_parity_q  <= err_parity_d;
      err_frame_q   <= err_frame_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign tx              = tx_q;
  assign bus.cmd_rdy     = cmd_rdy_q;
  assign bus.read_vld    = read_vld_q;
  assign bus.read_data   = read_data_q;
  assign bus.err_parity  = err_parity_q;
  assign bus.err_frame   = err_frame_q;
  assign bus.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_cmd_master.sv
// Directed bench for uart_cmd_master at CLK_DIV=4, 8E1, 2-bit gap, 8-bit reply timeout.
module tb_uart_cmd_master;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned FRAME_BITS = 8;
  localparam int unsigned PARITY_EN  = 1;
  localparam int unsigned PARITY_ODD = 0;
  localparam int unsigned STOP_BITS  = 1;
  localparam int unsigned GAP_BITS   = 2;
  localparam int unsigned RX_TO_BITS = 8;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic tx;

  int checks = 0;
  int errors = 0;

  int         rv_count = 0;
  logic [7:0] rv_data  = 8'h00;
  logic [2:0] rv_errs  = 3'b000;

  uart_cmd_master_if #(.FRAME_BITS(FRAME_BITS)) bus ();

  uart_cmd_master #(
    .CLK_DIV    (CLK_DIV),
    .FRAME_BITS (FRAME_BITS),
    .PARITY_EN  (PARITY_EN),
    .PARITY_ODD (PARITY_ODD),
    .STOP_BITS  (STOP_BITS),
    .GAP_BITS   (GAP_BITS),
    .RX_TO_BITS (RX_TO_BITS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .rx  (rx),
    .tx  (tx)
  );

  always #5 clk = ~clk;

  // Records every read completion with the flags valid in that cycle
  always @(negedge clk) begin
    if (bus.read_vld === 1'b1) begin
      rv_count = rv_count + 1;
      rv_data  = bus.read_data;
      rv_errs  = {bus.err_parity, bus.err_frame, bus.err_timeout};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Line order: start, payload LSB first, parity, stop
  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic flip, input logic stop);
    return {stop, (^d) ^ flip, d, 1'b0};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge of the first cycle after acceptance (cycle 0)
  task automatic accept_cmd(input logic [15:0] c);
    int w;
    w = 0;
    @(negedge clk);
    while (bus.cmd_rdy !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (bus.cmd_rdy !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait: cmd_rdy=%b after %0d cycles, required 1", bus.cmd_rdy, w);
    end
    bus.cmd_in  = c;
    bus.cmd_vld = 1'b1;
    @(negedge clk);
    bus.cmd_vld = 1'b0;
  endtask

  // Samples tx one clock into each bit-time, starting at cycle 1
  task automatic capture(input int nbits, output logic [31:0] bits);
    bits = '0;
    for (int k = 0; k < nbits; k++) begin
      step((k == 0) ? 1 : 4);
      bits[k] = tx;
    end
  endtask

  task automatic send_frame(input logic [10:0] f);
    for (int k = 0; k < 11; k++) begin
      rx = f[k];
      step(4);
    end
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx = 1'b1;
    bus.cmd_vld = 1'b0;
    bus.cmd_in = 16'h0000;
    step(2);
    checks++;
    if ({tx, bus.cmd_rdy, bus.read_vld} !== 3'b110) begin
      errors++;
      $display("FAIL reset_ctrl: tx/rdy/vld=%b, required 110", {tx, bus.cmd_rdy, bus.read_vld});
    end
    checks++;
    if (bus.read_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: read_data=%h, required 00", bus.read_data);
    end
    checks++;
    if ({bus.err_parity, bus.err_frame, bus.err_timeout} !== 3'b000) begin
      errors++;
      $display("FAIL reset_err: errs=%b, required 000",
               {bus.err_parity, bus.err_frame, bus.err_timeout});
    end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_write(input logic [15:0] c);
    logic [31:0] got;
    logic [31:0] exp;
    int rv0;
    rv0 = rv_count;
    exp = 32'({mk_frame(c[7:0], 1'b0, 1'b1), 2'b11, mk_frame(c[15:8], 1'b0, 1'b1)});
    accept_cmd(c);
    checks++;
    if (bus.cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL write_rdy_drop %h: cmd_rdy=%b, required 0", c, bus.cmd_rdy);
    end
    capture(24, got);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL write_tx %h: line=%h, required %h", c, got, exp);
    end
    step(4);
    checks++;
    if ({bus.cmd_rdy, tx} !== 2'b01) begin
      errors++;
      $display("FAIL write_rdy_97 %h: rdy/tx=%b, required 01", c, {bus.cmd_rdy, tx});
    end
    step(1);
    checks++;
    if (bus.cmd_rdy !== 1'b1) begin
      errors++;
      $display("FAIL write_rdy_98 %h: cmd_rdy=%b, required 1", c, bus.cmd_rdy);
    end
    checks++;
    if (rv_count !== rv0) begin
      errors++;
      $display("FAIL write_no_vld %h: read_vld pulses=%0d, required 0", c, rv_count - rv0);
    end
  endtask

  task automatic test_read(input logic [15:0] c, input logic [10:0] reply, input logic glitch,
                           input logic [7:0] exp_data, input logic [2:0] exp_errs);
    logic [31:0] got;
    int rv0;
    accept_cmd(c);
    capture(11, got);
    checks++;
    if (got !== 32'(mk_frame(c[15:8], 1'b0, 1'b1))) begin
      errors++;
      $display("FAIL read_tx %h: line=%h, required %h", c, got, 32'(mk_frame(c[15:8], 1'b0, 1'b1)));
    end
    step(4);
    if (glitch) begin
      rx = 1'b0;
      step(1);
      rx = 1'b1;
      step(7);
    end
    rv0 = rv_count;
    send_frame(reply);
    step(4);
    checks++;
    if (rv_count !== rv0 + 1) begin
      errors++;
      $display("FAIL read_pulses %h: read_vld pulses=%0d, required 1", c, rv_count - rv0);
    end
    checks++;
    if (rv_data !== exp_data || bus.read_data !== exp_data) begin
      errors++;
      $display("FAIL read_data %h: pulse=%h held=%h, required %h", c, rv_data, bus.read_data, exp_data);
    end
    checks++;
    if (rv_errs !== exp_errs) begin
      errors++;
      $display("FAIL read_errs %h: par/frm/to=%b, required %b", c, rv_errs, exp_errs);
    end
  endtask

  task automatic test_timeout(input logic [15:0] c, input logic [7:0] prev);
    logic [31:0] got;
    int rv0;
    rv0 = rv_count;
    accept_cmd(c);
    checks++;
    if (bus.err_parity !== 1'b0) begin
      errors++;
      $display("FAIL err_clear_on_accept: err_parity=%b, required 0", bus.err_parity);
    end
    capture(11, got);
    step(34);
    checks++;
    if (bus.read_vld !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: read_vld=%b at cycle 75, required 0", bus.read_vld);
    end
    step(1);
    checks++;
    if ({bus.read_vld, bus.err_timeout} !== 2'b11) begin
      errors++;
      $display("FAIL timeout_pulse: vld/to=%b at cycle 76, required 11", {bus.read_vld, bus.err_timeout});
    end
    checks++;
    if (bus.read_data !== prev) begin
      errors++;
      $display("FAIL timeout_data: read_data=%h, required %h", bus.read_data, prev);
    end
    step(1);
    checks++;
    if (bus.read_vld !== 1'b0 || rv_count !== rv0 + 1) begin
      errors++;
      $display("FAIL timeout_single: vld=%b pulses=%0d, required 0 and 1", bus.read_vld, rv_count - rv0);
    end
  endtask

  task automatic test_reset_mid_write();
    accept_cmd(16'h8A5C);
    step(6);
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL midwrite_tx_low: tx=%b at cycle 6, required 0", tx);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({tx, bus.cmd_rdy} !== 2'b11) begin
      errors++;
      $display("FAIL async_reset: tx/rdy=%b, required 11", {tx, bus.cmd_rdy});
    end
    step(2);
    rst = 1'b0;
    step(1);
    test_write(16'h8001);
  endtask

  initial begin
    test_reset();
    test_write(16'h8A5C);
    test_read(16'h1200, mk_frame(8'h3C, 1'b0, 1'b1), 1'b0, 8'h3C, 3'b000);
    test_read(16'h2300, mk_frame(8'h5A, 1'b1, 1'b1), 1'b0, 8'h5A, 3'b100);
    test_timeout(16'h3400, 8'h5A);
    test_read(16'h5600, mk_frame(8'hA5, 1'b0, 1'b0), 1'b1, 8'hA5, 3'b010);
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
